// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong squeeze path.
// Holds the rate geometry, the padding delimiter, the squeeze FSM encoding,
// the byte-index and length types, and the output-length clamp helpers.
package eaglesong_pkg;

  localparam int RATE_WORDS = 8;
  localparam int MAX_BYTES  = 32;
  localparam logic [7:0] DELIMITER = 8'h06;

  typedef enum logic {
    SQ_IDLE,
    SQ_STREAM
  } sq_state_t;

  typedef logic [4:0] byte_idx_t;
  typedef logic [6:0] out_len_t;

  localparam out_len_t MAX_LEN = out_len_t'(MAX_BYTES);

  // A zero length or anything beyond the rate is treated as a full-rate squeeze.
  function automatic logic len_is_illegal(input out_len_t l);
    return (l == '0) || (l > MAX_LEN);
  endfunction

  function automatic out_len_t clamp_len(input out_len_t l);
    return len_is_illegal(l) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/eaglesong_squeeze_byte_sel.sv
// Byte selector for the squeeze stream.
// Picks output byte idx from the captured rate words, little-endian within
// each word: byte 4*j+k is word j bits [8*k +: 8].
module eaglesong_squeeze_byte_sel
  import eaglesong_pkg::*;
(
  input  logic [31:0] words [RATE_WORDS],
  input  byte_idx_t   idx,
  output logic [7:0]  byte_out
);

  // Upper index bits choose the word, low two bits choose the byte lane.
  always_comb begin
    byte_out = words[idx[4:2]][{idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/eaglesong_squeeze_seq.sv
// Eaglesong squeeze serialiser.
// Captures the 8 rate words of the final permuted state together with a
// requested output length, then streams that many bytes to the digest
// consumer. Lengths of 0 or above 32 are clamped to 32 with a len_error pulse.
// Optional feature macro: EAGLESONG_SQUEEZE_DIGEST_EN adds a 256-bit digest
// register filled from the accepted bytes, plus digest_valid.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The producer keeps valid and its payload stable until
// that edge; ready may change freely and has no effect while valid is low.
// The squeeze FSM has a single state bit, and busy is exactly that bit.
module eaglesong_squeeze_seq
  import eaglesong_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       state_input [RATE_WORDS],
  input  logic [6:0]        output_length_bytes,
  input  logic              state_valid,
  output logic              state_ready,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [4:0]        byte_index,
  output logic              byte_last,
  output logic              len_error,
  output logic              busy
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
  ,
  output logic [255:0]      digest,
  output logic              digest_valid
`endif
);

  sq_state_t   fsm, fsm_next;
  byte_idx_t   idx, idx_next;
  out_len_t    len, len_next;
  logic [31:0] words [RATE_WORDS];
  logic        ready_next, valid_next, len_err_next;
  logic        capture, handshake;

  // Combinational byte picked from the captured copy; zero after reset since
  // both the words and the index reset to zero.
  eaglesong_squeeze_byte_sel u_byte_sel (
    .words    (words),
    .idx      (idx),
    .byte_out (byte_data)
  );

  assign byte_index = idx;
  assign busy       = (fsm != SQ_IDLE);

  // Last byte is the one at len-1; only meaningful while streaming.
  always_comb begin
    byte_last = (fsm == SQ_STREAM) && ({2'b00, idx} == (len - 7'd1));
  end

  // Next-state logic: capture in IDLE, advance or finish on each byte handshake.
  always_comb begin
    fsm_next     = fsm;
    idx_next     = idx;
    len_next     = len;
    ready_next   = state_ready;
    valid_next   = byte_valid;
    len_err_next = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    case (fsm)
      SQ_IDLE: begin
        ready_next = 1'b1;
        if (state_valid && state_ready) begin
          capture      = 1'b1;
          fsm_next     = SQ_STREAM;
          idx_next     = '0;
          len_next     = clamp_len(output_length_bytes);
          len_err_next = len_is_illegal(output_length_bytes);
          ready_next   = 1'b0;
          valid_next   = 1'b1;
        end
      end
      SQ_STREAM: begin
        if (byte_valid && byte_ready) begin
          handshake = 1'b1;
          if (byte_last) begin
            valid_next = 1'b0;
            ready_next = 1'b1;
            fsm_next   = SQ_IDLE;
          end else begin
            idx_next = idx + 5'd1;
          end
        end
      end
      default: begin
        fsm_next   = SQ_IDLE;
        valid_next = 1'b0;
        ready_next = 1'b0;
      end
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= SQ_IDLE;
      idx         <= '0;
      len         <= '0;
      state_ready <= 1'b0;
      byte_valid  <= 1'b0;
      len_error   <= 1'b0;
    end else begin
      fsm         <= fsm_next;
      idx         <= idx_next;
      len         <= len_next;
      state_ready <= ready_next;
      byte_valid  <= valid_next;
      len_error   <= len_err_next;
    end
  end

  // Private copy of the rate words so the producer may change them after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RATE_WORDS; i++) words[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < RATE_WORDS; i++) words[i] <= state_input[i];
    end
  end

`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
  // Digest assembly: clear on capture, drop each accepted byte into its lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digest       <= '0;
      digest_valid <= 1'b0;
    end else if (capture) begin
      digest       <= '0;
      digest_valid <= 1'b0;
    end else if (handshake) begin
      digest[{idx, 3'b000} +: 8] <= byte_data;
      if (byte_last) digest_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_eaglesong_squeeze_seq.sv
// Bench for the Eaglesong squeeze serialiser: directed and random squeezes
// checked against a byte-level model of the squeeze ordering.
module tb_eaglesong_squeeze_seq;
  import eaglesong_pkg::*;

  localparam int W = 14;  // {last, index[4:0], data[7:0]}

  typedef logic [31:0] words_t [RATE_WORDS];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  words_t      state_input;
  logic [6:0]  output_length_bytes = '0;
  logic        state_valid = 1'b0;
  logic        state_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [4:0]  byte_index;
  logic        byte_last;
  logic        len_error;
  logic        busy;
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
  logic [255:0] digest;
  logic         digest_valid;
  logic [255:0] exp_digest;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  got_q[$];
  int          len_err_cnt = 0;
  int          valid_cycles = 0;
  logic        ready_rand = 1'b0;
  logic        last_seen = 1'b0;

  eaglesong_squeeze_seq dut (
    .clk                 (clk),
    .rst                 (rst),
    .state_input         (state_input),
    .output_length_bytes (output_length_bytes),
    .state_valid         (state_valid),
    .state_ready         (state_ready),
    .byte_data           (byte_data),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .byte_index          (byte_index),
    .byte_last           (byte_last),
    .len_error           (len_error),
    .busy                (busy)
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    ,
    .digest              (digest),
    .digest_valid        (digest_valid)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int eff_len(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  function automatic logic [7:0] model_byte(input words_t w, input int i);
    return 8'(w[i / 4] >> (8 * (i % 4)));
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int j = 0; j < RATE_WORDS; j++) w[j] = $urandom;
    return w;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      byte_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input words_t w, input int l);
    int n;
    int t;
    n = eff_len(l);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 5'(i), model_byte(w, i)});
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    exp_digest = '0;
    for (int i = 0; i < n; i++) exp_digest[8 * i +: 8] = model_byte(w, i);
`endif
    t = 0;
    while (!state_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("state_ready_wait", state_ready, 1'b1);
    state_input = w;
    output_length_bytes = 7'(l);
    state_valid = 1'b1;
    @(posedge clk);
    #1;
    state_valid = 1'b0;
    state_input = rand_words();
    output_length_bytes = 7'($urandom_range(0, 127));
    @(negedge clk);
    check("len_error_timing", len_error, (l == 0 || l > 32));
    check("first_byte_valid", byte_valid, 1'b1);
    check("capture_state_ready", state_ready, 1'b0);
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    check("digest_cleared", {digest_valid, digest}, 257'd0);
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after_stream", busy, 1'b0);
    @(negedge clk);
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    check("digest_value", digest, exp_digest);
    check("digest_valid", digest_valid, 1'b1);
`endif
  endtask

  task automatic begin_txn(input logic rr);
    ready_rand = rr;
    len_err_cnt = 0;
    valid_cycles = 0;
    got_q.delete();
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_seen = 1'b0;
      end else begin
        if (last_seen) begin
          check("after_last_state_ready", state_ready, 1'b1);
          check("after_last_byte_valid", byte_valid, 1'b0);
          last_seen = 1'b0;
        end
        if (len_error) len_err_cnt++;
        if (byte_valid) begin
          valid_cycles++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte_valid", byte_valid, 1'b0);
          end else begin
            check("byte", {byte_last, byte_index, byte_data}, exp_q[0]);
            if (byte_ready) begin
              got_q.push_back(byte_data);
              last_seen = exp_q[0][W-1];
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    words_t w;
    int t;
    int l;
    logic [7:0] lit2 [5];
    lit2[0] = 8'hAA; lit2[1] = 8'hBB; lit2[2] = 8'hCC; lit2[3] = 8'hDD; lit2[4] = 8'h11;
    state_input = rand_words();

    // reset state
    #1;
    check("reset_outputs",
          {state_ready, byte_valid, byte_last, len_error, busy, byte_data, byte_index}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", state_ready, 1'b0);
    @(negedge clk);
    check("ready_after_reset", state_ready, 1'b1);

    // 1: full rate, counting pattern, no backpressure
    begin_txn(1'b0);
    for (int j = 0; j < RATE_WORDS; j++)
      w[j] = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
    send(w, 32);
    wait_done();
    check("t1_valid_cycles", 32'(valid_cycles), 32'd32);
    check("t1_count", 32'(got_q.size()), 32'd32);
    for (int i = 0; i < 32 && i < got_q.size(); i++) check("t1_byte_literal", got_q[i], 8'(i));
    check("t1_no_len_error", 32'(len_err_cnt), 32'd0);

    // 2: short squeeze across a word boundary
    begin_txn(1'b0);
    w = rand_words();
    w[0] = 32'hDDCCBBAA;
    w[1] = 32'h44332211;
    send(w, 5);
    wait_done();
    check("t2_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("t2_byte_literal", got_q[i], lit2[i]);
    check("t2_busy", busy, 1'b0);
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    check("t6_digest_literal", digest, 256'h11DDCCBBAA);
`endif

    // 3: full rate with random backpressure
    begin_txn(1'b1);
    send(rand_words(), 32);
    wait_done();
    check("t3_count", 32'(got_q.size()), 32'd32);

    // 4: clamped lengths and a legal full length
    begin_txn(1'b1);
    send(rand_words(), 0);
    wait_done();
    check("t4_len0_count", 32'(got_q.size()), 32'd32);
    check("t4_len0_err", 32'(len_err_cnt), 32'd1);
    begin_txn(1'b1);
    send(rand_words(), 40);
    wait_done();
    check("t4_len40_count", 32'(got_q.size()), 32'd32);
    check("t4_len40_err", 32'(len_err_cnt), 32'd1);
    begin_txn(1'b1);
    send(rand_words(), 32);
    wait_done();
    check("t4_len32_err", 32'(len_err_cnt), 32'd0);

    // 5: reset in the middle of a stream
    begin_txn(1'b0);
    send(rand_words(), 32);
    t = 0;
    while (!(byte_valid && byte_index == 5'd10) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_reached_idx10", byte_index, 5'd10);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_reset_outputs",
          {state_ready, byte_valid, byte_last, len_error, busy, byte_data, byte_index}, '0);
`ifdef EAGLESONG_SQUEEZE_DIGEST_EN
    check("t5_reset_digest", {digest_valid, digest}, 257'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin_txn(1'b0);
    send(rand_words(), 4);
    wait_done();
    check("t5_restart_count", 32'(got_q.size()), 32'd4);

    // random squeezes
    for (int k = 0; k < 10; k++) begin
      l = (k == 0) ? 1 : (k == 1) ? 33 : (k == 2) ? 31 : int'($urandom_range(0, 40));
      begin_txn(1'($urandom_range(0, 1)));
      send(rand_words(), l);
      wait_done();
      check("rand_count", 32'(got_q.size()), 32'(eff_len(l)));
      check("rand_len_err", 32'(len_err_cnt), (l == 0 || l > 32) ? 32'd1 : 32'd0);
    end

    // state_valid during a stream must be ignored
    begin_txn(1'b1);
    send(rand_words(), 8);
    state_valid = 1'b1;
    state_input = rand_words();
    output_length_bytes = 7'd3;
    repeat (3) @(negedge clk);
    state_valid = 1'b0;
    wait_done();
    check("holdoff_count", 32'(got_q.size()), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
